// File: rtl/reg_file_ctx.sv
// Parametrised MSP430 register file with constant generator, PC/SP/SR side-band
// updates and a save/restore context engine. Optional macro: REG_FILE_BYPASS_EN.
module reg_file_ctx #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int SAVE_FIRST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_s,
  input  logic [ADDR_W-1:0] rd_addr_d,
  input  logic [1:0]        as_mode,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] sp_in,
  input  logic [DATA_W-1:0] sr_in,
  input  logic              pc_we,
  input  logic              sp_we,
  input  logic              sr_we,
  input  logic [DATA_W-1:0] rst_vec,
  output logic [DATA_W-1:0] rd_data_s,
  output logic [DATA_W-1:0] rd_data_d,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] sp_out,
  output logic [DATA_W-1:0] sr_out,
  output logic              pc_valid,
  input  logic              ctx_save,
  input  logic              ctx_restore,
  output logic              ctx_busy,
  output logic              ctx_done,
  output logic [DATA_W-1:0] ctx_out_data,
  output logic              ctx_out_valid,
  input  logic              ctx_out_ready,
  input  logic [DATA_W-1:0] ctx_in_data,
  input  logic              ctx_in_valid,
  output logic              ctx_in_ready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } ctx_state_t;

  localparam logic [DATA_W-1:0] LSB_CLR   = {{(DATA_W-1){1'b1}}, 1'b0};
  localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO      = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(SAVE_FIRST);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_pc_valid;
  ctx_state_t        r_state;
  ctx_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_restore_beat;
  logic [NUM_REGS-1:0] w_wr_en;
  logic [DATA_W-1:0] w_wr_val [NUM_REGS];
  logic [DATA_W-1:0] w_val_s;
  logic [DATA_W-1:0] w_val_d;

  // Per-register write select: restore beat, then write port, then side-band.
  always_comb begin
    w_restore_beat = (r_state == ST_RESTORE) && ctx_in_valid;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_en[i]  = 1'b0;
      w_wr_val[i] = r_regs[i];
      if (!r_pc_valid || i == 3) begin
        w_wr_en[i] = 1'b0;
      end else if (w_restore_beat && r_idx == ADDR_W'(i)) begin
        w_wr_en[i]  = 1'b1;
        w_wr_val[i] = ctx_in_data;
      end else if (we && wr_addr == ADDR_W'(i)) begin
        w_wr_en[i]  = 1'b1;
        w_wr_val[i] = wr_data;
      end else if (i == 0 && pc_we) begin
        w_wr_en[i]  = 1'b1;
        w_wr_val[i] = pc_in;
      end else if (i == 1 && sp_we) begin
        w_wr_en[i]  = 1'b1;
        w_wr_val[i] = sp_in;
      end else if (i == 2 && sr_we) begin
        w_wr_en[i]  = 1'b1;
        w_wr_val[i] = sr_in;
      end else begin
        w_wr_en[i] = 1'b0;
      end
      // PC and SP are word aligned whatever the source.
      if (i < 2) begin
        w_wr_val[i] = w_wr_val[i] & LSB_CLR;
      end else begin
        w_wr_val[i] = w_wr_val[i];
      end
    end
  end

  // Register array; the first live cycle only loads the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= ZERO;
      end
      r_pc_valid <= 1'b0;
    end else begin
      r_pc_valid <= 1'b1;
      if (!r_pc_valid) begin
        r_regs[0] <= rst_vec & LSB_CLR;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_wr_en[i]) begin
            r_regs[i] <= w_wr_val[i];
          end
        end
      end
    end
  end

  // Context engine next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pc_valid && ctx_save) begin
          w_state_nxt = ST_SAVE;
          w_idx_nxt   = IDX_LAST;
        end else if (r_pc_valid && ctx_restore) begin
          w_state_nxt = ST_RESTORE;
          w_idx_nxt   = IDX_FIRST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SAVE: begin
        if (ctx_out_ready && r_idx == IDX_FIRST) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (ctx_out_ready) begin
          w_idx_nxt = r_idx - ADDR_W'(1);
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      ST_RESTORE: begin
        if (ctx_in_valid && r_idx == IDX_LAST) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (ctx_in_valid) begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Context engine state, index and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= {ADDR_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Read ports; R2/R3 on the source port double as the constant generator.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    w_val_s = w_wr_en[rd_addr_s] ? w_wr_val[rd_addr_s] : r_regs[rd_addr_s];
    w_val_d = w_wr_en[rd_addr_d] ? w_wr_val[rd_addr_d] : r_regs[rd_addr_d];
`else
    w_val_s = r_regs[rd_addr_s];
    w_val_d = r_regs[rd_addr_d];
`endif
    rd_data_s = w_val_s;
    if (rd_addr_s == ADDR_W'(2)) begin
      case (as_mode)
        2'b00:   rd_data_s = w_val_s;
        2'b01:   rd_data_s = ZERO;
        2'b10:   rd_data_s = DATA_W'(32'd4);
        2'b11:   rd_data_s = DATA_W'(32'd8);
        default: rd_data_s = w_val_s;
      endcase
    end else if (rd_addr_s == ADDR_W'(3)) begin
      case (as_mode)
        2'b00:   rd_data_s = ZERO;
        2'b01:   rd_data_s = DATA_W'(32'd1);
        2'b10:   rd_data_s = DATA_W'(32'd2);
        2'b11:   rd_data_s = ALL_ONES;
        default: rd_data_s = ZERO;
      endcase
    end else begin
      rd_data_s = w_val_s;
    end
    if (rd_addr_d == ADDR_W'(3)) begin
      rd_data_d = ZERO;
    end else begin
      rd_data_d = w_val_d;
    end
  end

  assign pc_out        = r_regs[0];
  assign sp_out        = r_regs[1];
  assign sr_out        = r_regs[2];
  assign pc_valid      = r_pc_valid;
  assign ctx_busy      = (r_state != ST_IDLE);
  assign ctx_done      = r_done;
  assign ctx_out_valid = (r_state == ST_SAVE);
  assign ctx_out_data  = r_regs[r_idx];
  assign ctx_in_ready  = (r_state == ST_RESTORE);

endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed self-checking bench for reg_file_ctx (default parameters).
module tb_reg_file_ctx;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_s;
  logic [3:0]  rd_addr_d;
  logic [1:0]  as_mode;
  logic [15:0] pc_in, sp_in, sr_in;
  logic        pc_we, sp_we, sr_we;
  logic [15:0] rst_vec;
  logic [15:0] rd_data_s, rd_data_d;
  logic [15:0] pc_out, sp_out, sr_out;
  logic        pc_valid;
  logic        ctx_save, ctx_restore, ctx_busy, ctx_done;
  logic [15:0] ctx_out_data;
  logic        ctx_out_valid, ctx_out_ready;
  logic [15:0] ctx_in_data;
  logic        ctx_in_valid, ctx_in_ready;

  int n_checks;
  int n_err;
  logic [15:0] cg3 [4] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
  logic [15:0] exp_byp;

  reg_file_ctx dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_s(rd_addr_s), .rd_addr_d(rd_addr_d), .as_mode(as_mode),
    .pc_in(pc_in), .sp_in(sp_in), .sr_in(sr_in),
    .pc_we(pc_we), .sp_we(sp_we), .sr_we(sr_we), .rst_vec(rst_vec),
    .rd_data_s(rd_data_s), .rd_data_d(rd_data_d),
    .pc_out(pc_out), .sp_out(sp_out), .sr_out(sr_out), .pc_valid(pc_valid),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done),
    .ctx_out_data(ctx_out_data), .ctx_out_valid(ctx_out_valid),
    .ctx_out_ready(ctx_out_ready),
    .ctx_in_data(ctx_in_data), .ctx_in_valid(ctx_in_valid),
    .ctx_in_ready(ctx_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int e, k, c, beats, n;
    logic got;
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; we = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
    rd_addr_s = 4'd0; rd_addr_d = 4'd0; as_mode = 2'b00;
    pc_in = 16'h0000; sp_in = 16'h0000; sr_in = 16'h0000;
    pc_we = 1'b0; sp_we = 1'b0; sr_we = 1'b0; rst_vec = 16'hF801;
    ctx_save = 1'b0; ctx_restore = 1'b0; ctx_out_ready = 1'b0;
    ctx_in_data = 16'h0000; ctx_in_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_valid", pc_valid, 0);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_busy", ctx_busy, 0);
    chk("rst_done", ctx_done, 0);
    chk("rst_out_valid", ctx_out_valid, 0);
    chk("rst_in_ready", ctx_in_ready, 0);

    // first live edge: vector load only, write and save request ignored
    @(negedge clk);
    rst_n = 1'b1; we = 1'b1; wr_addr = 4'd5; wr_data = 16'h1111; ctx_save = 1'b1;
    @(negedge clk);
    we = 1'b0; ctx_save = 1'b0; rd_addr_d = 4'd5;
    #1;
    chk("vec_pc", pc_out, 16'hF800);
    chk("vec_pc_valid", pc_valid, 1);
    chk("vec_busy", ctx_busy, 0);
    chk("vec_out_valid", ctx_out_valid, 0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      rd_addr_d = 4'(i);
      #1;
      chk("rst_reg_zero", rd_data_d, 16'h0000);
    end

    // constant generator
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      rd_addr_s = 4'd3; as_mode = 2'(m);
      #1;
      chk("cg_r3", rd_data_s, cg3[m]);
    end
    @(negedge clk);
    rd_addr_s = 4'd2; as_mode = 2'b10;
    #1;
    chk("cg_r2_4", rd_data_s, 16'h0004);
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd2; wr_data = 16'h00AB;
    @(negedge clk);
    we = 1'b0; as_mode = 2'b00;
    #1;
    chk("cg_r2_raw", rd_data_s, 16'h00AB);
    @(negedge clk);
    as_mode = 2'b11;
    #1;
    chk("cg_r2_8", rd_data_s, 16'h0008);
    @(negedge clk);
    as_mode = 2'b01;
    #1;
    chk("cg_r2_0", rd_data_s, 16'h0000);
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr_d = 4'd3;
    #1;
    chk("r3_wr_same", rd_data_d, 16'h0000);
    @(negedge clk);
    we = 1'b0; rd_addr_s = 4'd3; as_mode = 2'b00;
    #1;
    chk("r3_wr_d", rd_data_d, 16'h0000);
    chk("r3_wr_s", rd_data_s, 16'h0000);

    // write priority and bit-0 forcing
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd0; wr_data = 16'h4401; pc_we = 1'b1; pc_in = 16'h0200;
    sp_we = 1'b1; sp_in = 16'h1235; sr_we = 1'b1; sr_in = 16'h0107;
    @(negedge clk);
    we = 1'b0; pc_we = 1'b0; sp_we = 1'b0; sr_we = 1'b0;
    #1;
    chk("prio_pc", pc_out, 16'h4400);
    chk("sb_sp", sp_out, 16'h1234);
    chk("sb_sr", sr_out, 16'h0107);
    @(negedge clk);
    pc_we = 1'b1; pc_in = 16'h0203;
    @(negedge clk);
    pc_we = 1'b0;
    #1;
    chk("sb_pc", pc_out, 16'h0202);

    // preload R4..R15
    for (int i = 4; i < 16; i++) begin
      @(negedge clk);
      we = 1'b1; wr_addr = 4'(i); wr_data = 16'hA000 | 16'(i);
    end
    @(negedge clk);
    we = 1'b0;

    // save with toggling back-pressure
    @(negedge clk);
    ctx_save = 1'b1; ctx_out_ready = 1'b0;
    @(negedge clk);
    ctx_save = 1'b0;
    #1;
    chk("save_busy", ctx_busy, 1);
    chk("save_first_valid", ctx_out_valid, 1);
    chk("save_first_data", ctx_out_data, 16'hA00F);
    chk("save_in_ready", ctx_in_ready, 0);
    e = 15; beats = 0; c = 0;
    while (beats < 12 && c < 60) begin
      @(negedge clk);
      ctx_out_ready = (c % 2 == 0);
      we = (c == 0); wr_addr = 4'd15; wr_data = 16'hDEAD;
      #1;
      chk("save_valid", ctx_out_valid, 1);
      chk("save_data", ctx_out_data, 16'hA000 + e);
      chk("save_done_early", ctx_done, 0);
      if (ctx_out_ready) begin
        e--; beats++;
      end
      c++;
    end
    chk("save_beats", beats, 12);
    @(negedge clk);
    ctx_out_ready = 1'b0; we = 1'b0; rd_addr_d = 4'd15;
    #1;
    chk("save_done", ctx_done, 1);
    chk("save_busy_end", ctx_busy, 0);
    chk("save_valid_end", ctx_out_valid, 0);
    chk("save_wr_applied", rd_data_d, 16'hDEAD);
    @(negedge clk);
    #1;
    chk("save_done_once", ctx_done, 0);

    // restore with gaps and a colliding write to R7
    @(negedge clk);
    ctx_restore = 1'b1;
    @(negedge clk);
    ctx_restore = 1'b0;
    #1;
    chk("rest_busy", ctx_busy, 1);
    chk("rest_ready", ctx_in_ready, 1);
    k = 4; c = 0;
    while (k < 16 && c < 80) begin
      @(negedge clk);
      ctx_in_valid = (c % 3 != 1);
      ctx_in_data = 16'hC000 | 16'(k);
      we = ctx_in_valid && (k == 7); wr_addr = 4'd7; wr_data = 16'h7777;
      #1;
      chk("rest_ready_beat", ctx_in_ready, 1);
      chk("rest_done_early", ctx_done, 0);
      if (ctx_in_valid) k++;
      c++;
    end
    chk("rest_beats", k, 16);
    @(negedge clk);
    ctx_in_valid = 1'b0; we = 1'b0;
    #1;
    chk("rest_done", ctx_done, 1);
    chk("rest_busy_end", ctx_busy, 0);
    chk("rest_ready_end", ctx_in_ready, 0);
    for (int i = 4; i < 16; i++) begin
      @(negedge clk);
      rd_addr_d = 4'(i);
      #1;
      chk("rest_reg", rd_data_d, 16'hC000 | 16'(i));
      if (i == 4) chk("rest_done_once", ctx_done, 0);
    end

    // reset in the middle of a restore
    @(negedge clk);
    ctx_restore = 1'b1;
    @(negedge clk);
    ctx_restore = 1'b0; ctx_in_valid = 1'b1; ctx_in_data = 16'hD004;
    @(negedge clk);
    ctx_in_data = 16'hD005; rd_addr_d = 4'd4;
    #1;
    chk("abort_partial", rd_data_d, 16'hD004);
    @(negedge clk);
    ctx_in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("abort_busy", ctx_busy, 0);
    chk("abort_ready", ctx_in_ready, 0);
    chk("abort_pc_valid", pc_valid, 0);
    chk("abort_r4", rd_data_d, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", ctx_done, 0);
      chk("abort_idle", ctx_busy, 0);
    end
    chk("abort_pc_reload", pc_out, 16'hF800);
    rd_addr_d = 4'd5;
    #1;
    chk("abort_r5", rd_data_d, 16'h0000);

    // same-cycle read of a register being written
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    @(negedge clk);
    wr_data = 16'hBEEF; rd_addr_d = 4'd5; rd_addr_s = 4'd5; as_mode = 2'b00;
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 16'hBEEF;
`else
    exp_byp = 16'h1234;
`endif
    #1;
    chk("byp_d", rd_data_d, exp_byp);
    chk("byp_s", rd_data_s, exp_byp);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("byp_after", rd_data_d, 16'hBEEF);

    // save wins over restore; request-to-done latency without back-pressure
    @(negedge clk);
    ctx_save = 1'b1; ctx_restore = 1'b1; ctx_out_ready = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      ctx_save = 1'b0; ctx_restore = 1'b0;
      #1;
      n++;
      if (n == 1) begin
        chk("both_save_valid", ctx_out_valid, 1);
        chk("both_no_restore", ctx_in_ready, 0);
      end
      if (ctx_done === 1'b1) got = 1'b1;
    end
    chk("save_latency", n, 13);
    ctx_out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
